// File: rtl/ps2_keyboard_multi_pkg.sv
// Shared PS/2 byte constants, key/event records and the deframer state type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_E1     = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Bytes that carry no key information and must not disturb the prefix flags.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_E1) || (b == PS2_BAT) || (b == PS2_ACK) ||
               (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_keyboard_multi_if.sv
// Key-event stream from the keyboard decoder to its consumer (valid/ready pop).
interface ps2_keyboard_multi_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_keyboard_multi_rx_frame.sv
// PS/2 pin synchronizer, falling-edge detector, 11-bit deframer and inter-edge timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;
    rx_state_t              state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   parity;
    logic [TW-1:0]          to_cnt;

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            clk_prev   <= 1'b0;
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            to_cnt     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps_data};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall || state == RX_IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (!fall && state != RX_IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= RX_IDLE;
            end else if (fall) begin
                unique case (state)
                    RX_IDLE: begin
                        if (!bit_in) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity <= bit_in;
                        state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (bit_in && (^{shreg, parity})) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_multi.sv
// PS/2 keyboard decoder: prefix handling, held-key table and make/break event FIFO.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make events.
module ps2_keyboard_multi
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    psClk,
    input  logic                    psData,
    output logic [9*NUM_KEYS-1:0]   keyCodes,
    output logic [NUM_KEYS-1:0]     keyValid,
    ps2_keyboard_multi_if.master    ev,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_rx_frame #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (Clk),
        .rst       (Reset),
        .ps_clk    (psClk),
        .ps_data   (psData),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    logic    ext_flag;
    logic    brk_flag;
    logic    ev_pend;
    ev_t     ev_cur;
    key_t    keys [NUM_KEYS];
    ev_t     mem  [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    logic          hit;
    logic [KW-1:0] hit_idx;
    logic          free_found;
    logic [KW-1:0] free_idx;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    key_t          cur_key;
    ev_t           head;

    assign cur_key = '{ext: ev_cur.ext, code: ev_cur.code};

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keyValid[i] && keys[i] == cur_key && !hit) begin
                hit     = 1'b1;
                hit_idx = KW'(i);
            end
            if (!keyValid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = KW'(i);
            end
        end
    end

    always_comb begin
`ifdef PS2_TYPEMATIC_FILTER_EN
        push_req = ev_pend && !(!ev_cur.brk && hit);
`else
        push_req = ev_pend;
`endif
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && ev.ev_ready;
    assign push  = push_req && (!full || pop);
    assign head  = mem[rptr[AW-1:0]];

    assign ev.ev_valid = !empty;
    assign ev.ev_code  = head.code;
    assign ev.ev_ext   = head.ext;
    assign ev.ev_break = head.brk;

    always_comb begin
        keyCodes = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            keyCodes[9*i +: 9] = keys[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            ev_pend  <= 1'b0;
            ev_cur   <= '0;
            keyValid <= '0;
            overflow <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            ev_pend <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk_flag <= 1'b1;
                end else if (!is_ignored(rx_byte)) begin
                    ev_cur   <= '{code: rx_byte, ext: ext_flag, brk: brk_flag};
                    ev_pend  <= 1'b1;
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            // Table and FIFO both act on the event formed in the previous cycle.
            if (ev_pend) begin
                if (!ev_cur.brk) begin
                    if (!hit) begin
                        if (free_found) begin
                            keys[free_idx]     <= cur_key;
                            keyValid[free_idx] <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end else if (hit) begin
                    keys[hit_idx]     <= '0;
                    keyValid[hit_idx] <= 1'b0;
                end
            end

            if (push) begin
                mem[wptr[AW-1:0]] <= ev_cur;
                wptr              <= wptr + 1'b1;
            end
            if (push_req && full && !pop) overflow <= 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

endmodule
